// File: rtl/cordic_scheduler.sv
// Sequences the single shared pipelined CORDIC: truncates filter X/Y words, launches one
// conversion at a time, holds one pending sample and gates results while the filters settle.
module cordic_scheduler #(
    parameter int IW          = 32,
    parameter int CW          = 17,
    parameter int LAT         = 18,
    parameter int SETTLE_BASE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] x_in,
    input  logic [IW-1:0] y_in,
    input  logic          in_valid,
    input  logic [3:0]    tc,
    input  logic [1:0]    gain,
    output logic [CW-1:0] cx_o,
    output logic [CW-1:0] cy_o,
    output logic          c_start,
    input  logic [CW-1:0] c_mag,
    input  logic [CW-1:0] c_ang,
    output logic [CW-1:0] mag,
    output logic [CW-1:0] ang,
    output logic          out_valid,
    output logic          settled,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    localparam int WCW = $clog2(LAT);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WCW-1:0]  wait_cnt;
    logic            pend_full;
    logic [CW-1:0]   pend_x;
    logic [CW-1:0]   pend_y;
    logic [19:0]     settle_cnt;
    logic [3:0]      tc_q;
    logic [1:0]      gain_q;

    logic            reload;
    logic            launch;
    logic            store;
    logic            drop;
    logic [CW-1:0]   x_trunc;
    logic [CW-1:0]   y_trunc;
    logic            unused_lsbs;

    assign x_trunc     = x_in[IW-1 -: CW];
    assign y_trunc     = y_in[IW-1 -: CW];
    assign unused_lsbs = ^{x_in[IW-CW-1:0], y_in[IW-CW-1:0]};

    assign reload  = (tc != tc_q) || (gain != gain_q);
    // A fresh strobe during CAPTURE is launched directly and takes priority over the buffered sample.
    assign launch  = ((state == IDLE) && in_valid) ||
                     ((state == CAPTURE) && (in_valid || pend_full));
    assign store   = in_valid && ((state == LOAD) || (state == WAIT));
    assign drop    = in_valid && pend_full && (state != IDLE);

    assign c_start = (state == LOAD);
    assign busy    = (state != IDLE);
    assign settled = (settle_cnt == 20'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (in_valid || pend_full) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT spans LAT-1 cycles so CAPTURE lines up with the result LAT cycles after c_start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt   <= '0;
            cx_o       <= '0;
            cy_o       <= '0;
            mag        <= '0;
            ang        <= '0;
            out_valid  <= 1'b0;
            pend_full  <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            drop_cnt   <= 8'd0;
            tc_q       <= 4'd0;
            gain_q     <= 2'd0;
            settle_cnt <= 20'(SETTLE_BASE);
        end else begin
            tc_q      <= tc;
            gain_q    <= gain;
            out_valid <= 1'b0;

            if (state == LOAD) begin
                wait_cnt <= WCW'(LAT - 2);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WCW'(1);
            end

            if (launch) begin
                cx_o <= in_valid ? x_trunc : pend_x;
                cy_o <= in_valid ? y_trunc : pend_y;
            end

            if (state == CAPTURE) begin
                mag       <= c_mag;
                ang       <= c_ang;
                out_valid <= (settle_cnt == 20'd0);
                pend_full <= 1'b0;
            end else if (store) begin
                pend_x    <= x_trunc;
                pend_y    <= y_trunc;
                pend_full <= 1'b1;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (reload) begin
                settle_cnt <= 20'(SETTLE_BASE) << tc;
            end else if ((state == CAPTURE) && (settle_cnt != 20'd0)) begin
                settle_cnt <= settle_cnt - 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler: a behavioural CORDIC stand-in plus a
// transaction-level scheduling model predict launches, results and drop counts.
module tb_cordic_scheduler;

    localparam int IW  = 32;
    localparam int CW  = 17;
    localparam int LAT = 18;
    localparam int SB  = 4;

    typedef struct {
        int            cyc;
        logic [CW-1:0] a;
        logic [CW-1:0] b;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] x_in = '0;
    logic [IW-1:0] y_in = '0;
    logic          in_valid = 1'b0;
    logic [3:0]    tc = 4'd0;
    logic [1:0]    gain = 2'd0;
    logic [CW-1:0] cx_o, cy_o, mag, ang;
    logic [CW-1:0] c_mag = '0;
    logic [CW-1:0] c_ang = '0;
    logic          c_start, out_valid, settled, busy;
    logic [7:0]    drop_cnt;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    ev_t launches[$];
    ev_t outs[$];
    ev_t expl[$];
    ev_t arrivals[$];
    int  exp_drops;
    int  busy_cycles = 0;
    int  back2back = 0;
    logic prev_start = 1'b0;

    logic [CW-1:0] m_mag, m_ang;
    int            m_ready = -1;
    logic          m_armed = 1'b0;

    cordic_scheduler #(.IW(IW), .CW(CW), .LAT(LAT), .SETTLE_BASE(SB)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .in_valid(in_valid),
        .tc(tc), .gain(gain), .cx_o(cx_o), .cy_o(cy_o), .c_start(c_start),
        .c_mag(c_mag), .c_ang(c_ang), .mag(mag), .ang(ang), .out_valid(out_valid),
        .settled(settled), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] trunc(input logic [IW-1:0] v);
        return CW'(v >> (IW - CW));
    endfunction

    function automatic logic [CW-1:0] fmag(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return a ^ b;
    endfunction

    function automatic logic [CW-1:0] fang(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return a + b;
    endfunction

    // Stand-in CORDIC: result shows up exactly LAT cycles after c_start, junk otherwise.
    always @(posedge clk) begin
        if (c_start === 1'b1) begin
            m_mag   = fmag(cx_o, cy_o);
            m_ang   = fang(cx_o, cy_o);
            m_ready = cyc + LAT;
            m_armed = 1'b1;
        end
        cyc = cyc + 1;
        if (m_armed && cyc == m_ready) begin
            c_mag   <= m_mag;
            c_ang   <= m_ang;
            m_armed = 1'b0;
        end else begin
            c_mag <= CW'($urandom);
            c_ang <= CW'($urandom);
        end
    end

    always @(negedge clk) begin
        if (c_start === 1'b1) begin
            launches.push_back('{cyc, cx_o, cy_o});
            if (prev_start) back2back++;
        end
        prev_start = (c_start === 1'b1);
        if (out_valid === 1'b1) outs.push_back('{cyc, mag, ang});
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] x, input logic [IW-1:0] y, output int t);
        x_in     = x;
        y_in     = y;
        in_valid = 1'b1;
        t        = cyc;
        arrivals.push_back('{cyc, trunc(x), trunc(y)});
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        launches.delete();
        outs.delete();
        arrivals.delete();
        busy_cycles = 0;
    endtask

    // One converter, one buffer slot: an arrival while a conversion is open (launch..capture)
    // replaces the slot; the slot is launched the cycle after that conversion's capture.
    task automatic model_schedule();
        int   cap;
        bit   active;
        bit   pf;
        ev_t  pend;
        expl.delete();
        exp_drops = 0;
        active = 0;
        pf = 0;
        cap = 0;
        foreach (arrivals[i]) begin
            while (active && arrivals[i].cyc > cap) begin
                if (pf) begin
                    expl.push_back('{cap + 1, pend.a, pend.b});
                    cap = cap + 1 + LAT;
                    pf  = 0;
                end else begin
                    active = 0;
                end
            end
            if (!active) begin
                expl.push_back('{arrivals[i].cyc + 1, arrivals[i].a, arrivals[i].b});
                cap    = arrivals[i].cyc + 1 + LAT;
                active = 1;
            end else begin
                if (pf) exp_drops++;
                pend = arrivals[i];
                pf   = 1;
            end
        end
        if (active && pf) expl.push_back('{cap + 1, pend.a, pend.b});
    endtask

    task automatic check_against_model(input string tag);
        model_schedule();
        nchk++;
        if (launches.size() !== expl.size()) begin
            nerr++;
            $display("[TB] FAIL %s launch_count: got %0d want %0d", tag, launches.size(), expl.size());
        end
        nchk++;
        if (outs.size() !== expl.size()) begin
            nerr++;
            $display("[TB] FAIL %s result_count: got %0d want %0d", tag, outs.size(), expl.size());
        end
        for (int i = 0; i < expl.size() && i < launches.size() && i < outs.size(); i++) begin
            nchk++;
            if (launches[i].cyc !== expl[i].cyc || launches[i].a !== expl[i].a || launches[i].b !== expl[i].b) begin
                nerr++;
                $display("[TB] FAIL %s launch[%0d]: got cyc %0d x %h y %h want cyc %0d x %h y %h", tag, i,
                         launches[i].cyc, launches[i].a, launches[i].b, expl[i].cyc, expl[i].a, expl[i].b);
            end
            nchk++;
            if (outs[i].cyc !== expl[i].cyc + LAT + 1 || outs[i].a !== fmag(expl[i].a, expl[i].b) ||
                outs[i].b !== fang(expl[i].a, expl[i].b)) begin
                nerr++;
                $display("[TB] FAIL %s result[%0d]: got cyc %0d mag %h ang %h want cyc %0d mag %h ang %h", tag, i,
                         outs[i].cyc, outs[i].a, outs[i].b, expl[i].cyc + LAT + 1,
                         fmag(expl[i].a, expl[i].b), fang(expl[i].a, expl[i].b));
            end
        end
    endtask

    task automatic test_reset();
        step(3);
        nchk++;
        if ({cx_o, cy_o, mag, ang} !== '0 || {c_start, out_valid, busy, settled} !== 4'b0 || drop_cnt !== 8'd0) begin
            nerr++;
            $display("[TB] FAIL reset_values: got cx %h cy %h mag %h ang %h flags %b drop %0d want all zero",
                     cx_o, cy_o, mag, ang, {c_start, out_valid, busy, settled}, drop_cnt);
        end
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_settle_from_reset();
        int t;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            send(32'h4000_0000, 32'h0, t);
            step(LAT + 4);
            if (i == 2) begin
                nchk++;
                if (settled !== 1'b0) begin
                    nerr++;
                    $display("[TB] FAIL settled_after_3: got %b want 0", settled);
                end
            end
        end
        nchk++;
        if (outs.size() !== 0) begin
            nerr++;
            $display("[TB] FAIL initial_suppress: got %0d results want 0", outs.size());
        end
        nchk++;
        if (settled !== 1'b1) begin
            nerr++;
            $display("[TB] FAIL settled_after_4: got %b want 1", settled);
        end
        send(32'h4000_0000, 32'h0, t);
        step(LAT + 4);
        nchk++;
        if (outs.size() !== 1 || outs[0].cyc !== t + LAT + 2 || outs[0].a !== 17'h08000) begin
            nerr++;
            $display("[TB] FAIL fifth_result: got n %0d cyc %0d mag %h want n 1 cyc %0d mag 08000",
                     outs.size(), (outs.size() > 0) ? outs[0].cyc : -1,
                     (outs.size() > 0) ? outs[0].a : 17'h0, t + LAT + 2);
        end
    endtask

    task automatic test_single();
        int t;
        logic [IW-1:0] y;
        clear_logs();
        y = $urandom;
        send(32'hFFFF_8000, y, t);
        step(LAT + 4);
        nchk++;
        if (launches.size() !== 1 || launches[0].cyc !== t + 1 || launches[0].a !== 17'h1FFFF ||
            launches[0].b !== trunc(y)) begin
            nerr++;
            $display("[TB] FAIL single_launch: got n %0d cyc %0d cx %h want n 1 cyc %0d cx 1ffff",
                     launches.size(), (launches.size() > 0) ? launches[0].cyc : -1,
                     (launches.size() > 0) ? launches[0].a : 17'h0, t + 1);
        end
        nchk++;
        if (busy_cycles !== LAT + 1) begin
            nerr++;
            $display("[TB] FAIL single_busy: got %0d cycles want %0d", busy_cycles, LAT + 1);
        end
        check_against_model("single");
    endtask

    task automatic test_overwrite();
        int t, t2, t3;
        int d0;
        clear_logs();
        d0 = drop_cnt;
        send($urandom, $urandom, t);
        step(2);
        send($urandom, $urandom, t2);
        step(2);
        send($urandom, $urandom, t3);
        step(2 * LAT + 8);
        nchk++;
        if (launches.size() !== 2 || launches[1].cyc !== t + LAT + 2 || launches[1].a !== arrivals[2].a) begin
            nerr++;
            $display("[TB] FAIL overwrite_launch: got n %0d cyc %0d want n 2 cyc %0d",
                     launches.size(), (launches.size() > 1) ? launches[1].cyc : -1, t + LAT + 2);
        end
        nchk++;
        if (int'(drop_cnt) !== d0 + 1) begin
            nerr++;
            $display("[TB] FAIL overwrite_drop: got %0d want %0d", drop_cnt, d0 + 1);
        end
        check_against_model("overwrite");
    endtask

    task automatic test_capture_coincident();
        int t, t2;
        int d0;
        clear_logs();
        d0 = drop_cnt;
        send($urandom, $urandom, t);
        step(LAT);
        send($urandom, $urandom, t2);
        step(2 * LAT + 8);
        nchk++;
        if (t2 !== t + 1 + LAT || launches.size() !== 2 || launches[1].cyc !== t + LAT + 2 ||
            launches[1].a !== arrivals[1].a || launches[1].b !== arrivals[1].b) begin
            nerr++;
            $display("[TB] FAIL coincident_launch: got n %0d cyc %0d want n 2 cyc %0d",
                     launches.size(), (launches.size() > 1) ? launches[1].cyc : -1, t + LAT + 2);
        end
        nchk++;
        if (int'(drop_cnt) !== d0) begin
            nerr++;
            $display("[TB] FAIL coincident_drop: got %0d want %0d", drop_cnt, d0);
        end
        check_against_model("coincident");
    endtask

    task automatic test_random();
        int t;
        int d0;
        clear_logs();
        d0 = drop_cnt;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(24, 1) - 1);
            send($urandom, $urandom, t);
        end
        step(2 * LAT + 10);
        check_against_model("random");
        nchk++;
        if (int'(drop_cnt) !== d0 + exp_drops) begin
            nerr++;
            $display("[TB] FAIL random_drops: got %0d want %0d", drop_cnt, d0 + exp_drops);
        end
    endtask

    task automatic run_convs(input int n, output int nout);
        int t;
        int n0;
        n0 = outs.size();
        for (int i = 0; i < n; i++) begin
            send($urandom, $urandom, t);
            step(LAT + 3);
        end
        nout = outs.size() - n0;
    endtask

    task automatic test_settling_change();
        int n;
        clear_logs();
        tc = 4'd3;
        step(1);
        nchk++;
        if (settled !== 1'b0) begin
            nerr++;
            $display("[TB] FAIL tc_unsettle: got %b want 0", settled);
        end
        run_convs(32, n);
        nchk++;
        if (n !== 0) begin
            nerr++;
            $display("[TB] FAIL tc_suppress: got %0d results want 0", n);
        end
        run_convs(1, n);
        nchk++;
        if (n !== 1) begin
            nerr++;
            $display("[TB] FAIL tc_33rd: got %0d results want 1", n);
        end
        gain = 2'd1;
        step(1);
        run_convs(10, n);
        gain = 2'd2;
        step(1);
        run_convs(32, n);
        nchk++;
        if (n !== 0) begin
            nerr++;
            $display("[TB] FAIL gain_restart: got %0d results want 0", n);
        end
        run_convs(1, n);
        nchk++;
        if (n !== 1) begin
            nerr++;
            $display("[TB] FAIL gain_33rd: got %0d results want 1", n);
        end
        tc = 4'd0;
        gain = 2'd0;
        step(2);
    endtask

    task automatic test_reset_mid();
        int t;
        send($urandom | 32'h8000_0000, $urandom | 32'h8000_0000, t);
        step(8);
        rst = 1'b0;
        step(1);
        nchk++;
        if ({cx_o, cy_o, mag, ang} !== '0 || {c_start, out_valid, busy, settled} !== 4'b0 || drop_cnt !== 8'd0) begin
            nerr++;
            $display("[TB] FAIL midreset_values: got cx %h cy %h mag %h ang %h flags %b drop %0d want all zero",
                     cx_o, cy_o, mag, ang, {c_start, out_valid, busy, settled}, drop_cnt);
        end
        rst = 1'b1;
        clear_logs();
        step(LAT + 10);
        nchk++;
        if (outs.size() !== 0 || launches.size() !== 0 || mag !== '0 || busy_cycles !== 0) begin
            nerr++;
            $display("[TB] FAIL midreset_ignore: got results %0d launches %0d mag %h busy %0d want 0 0 0 0",
                     outs.size(), launches.size(), mag, busy_cycles);
        end
    endtask

    task automatic test_drop_saturation();
        int t;
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            send($urandom, $urandom, t);
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        step(2 * LAT + 10);
        model_schedule();
        nchk++;
        if (exp_drops < 300 || drop_cnt !== 8'd255) begin
            nerr++;
            $display("[TB] FAIL drop_saturate: got %0d want 255 (events %0d)", drop_cnt, exp_drops);
        end
        nchk++;
        if (launches.size() !== expl.size()) begin
            nerr++;
            $display("[TB] FAIL flood_launches: got %0d want %0d", launches.size(), expl.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_settle_from_reset();
        test_single();
        test_overwrite();
        test_capture_coincident();
        test_random();
        test_settling_change();
        test_reset_mid();
        test_drop_saturation();
        nchk++;
        if (back2back !== 0) begin
            nerr++;
            $display("[TB] FAIL start_spacing: got %0d back-to-back starts want 0", back2back);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
